col_fifo_drain: RTL and testbench
=================================

Name: col_fifo_drain

Overview:
- Parametrised successor to the column-FIFO unloader that sits between the systolic-array per-column output FIFOs and the final result FIFO.
- Pops one word from every participating column FIFO and serialises the words, one per cycle, into the final FIFO.
- Adds configurable data width, column order and a skip-empty mode.
- Adds downstream backpressure, column tagging, synchronous reset and a completed-row counter.

Parameters:
- COL, 3, number of column FIFOs (>=2).
- DW, 9, data width per column word.
- MSB_FIRST, 1, 1: emit column COL-1 down to 0; 0: emit column 0 up to COL-1.
- SKIP_EMPTY, 0, 0: launch only when all FIFOs are non-empty; 1: launch when any FIFO is non-empty, and read/emit only the non-empty ones.
- RCW, 16, width of the completed-row counter.

Ports:
- i_clk, in, 1, clock; all logic is on the rising edge.
- i_rst, in, 1, reset; synchronous, active-high.
- i_data, in, DW*COL, column words; column c occupies bits [(c+1)*DW-1 : c*DW].
- i_fifo_empty, in, COL, per-column FIFO empty flags.
- i_out_full, in, 1, final FIFO full; stalls emission.
- o_read_enable, out, COL, per-column FIFO pop, single-cycle pulse.
- o_data, out, DW, serialised word.
- wr_en_final_fifo, out, 1, o_data valid / write strobe to the final FIFO.
- o_col_id, out, max(1,$clog2(COL)), source column of o_data.
- o_busy, out, 1, high in any state other than IDLE.
- o_rows, out, RCW, number of completed rows; wraps modulo 2^RCW.

Behaviour:
- Reset (i_rst high at an edge): state goes to IDLE. o_read_enable, o_data, wr_en_final_fifo, o_col_id, o_busy and o_rows all go to 0. The snapshot register and column mask are cleared. A partial row in progress is discarded with no further writes; FIFO entries already popped are lost by design.
- Launch condition:
  - SKIP_EMPTY=0: i_fifo_empty == 0.
  - SKIP_EMPTY=1: i_fifo_empty != all-ones.
- IDLE:
  - On launch, register mask = ~i_fifo_empty. In SKIP_EMPTY=0 the mask is all-ones.
  - Drive o_read_enable = mask for exactly one cycle, then go to WAIT.
  - wr_en_final_fifo = 0.
- WAIT: o_read_enable = 0. Allows one cycle of FIFO read latency. Next state is SNAP.
- SNAP:
  - Capture i_data into the snapshot register.
  - Load the column pointer with the first masked column in emission order.
  - Next state is SEND.
- SEND, each edge:
  - If i_out_full = 0: o_data = snapshot word at the pointer, o_col_id = pointer, wr_en_final_fifo = 1. Advance the pointer to the next masked column in emission order.
  - If i_out_full = 1: wr_en_final_fifo = 0, and o_data and o_col_id are held.
  - When the last masked column is emitted: o_rows increments and state returns to IDLE. wr_en_final_fifo clears in IDLE on the following edge.
- Latency:
  - Launch edge E produces o_read_enable high during E+1.
  - The first write strobe is visible after edge E+3, assuming no stall.
  - N masked columns take N write cycles plus stall cycles.
- Back-to-back rows: IDLE can re-launch on the same edge that clears wr_en_final_fifo. Minimum row period is N+3 cycles.
- i_fifo_empty changes after the mask is captured do not affect the current row.
- i_out_full is sampled only in SEND. A stall on the last word holds the state in SEND.
- The pointer never selects an unmasked column. Unmasked columns are never popped.
- o_busy = (state != IDLE).

Test Plan:
- Reset, then COL=3, DW=9, MSB_FIRST=1, all FIFOs non-empty, column words c0=0x011, c1=0x022, c2=0x033, i_out_full=0 → o_read_enable=3'b111 for 1 cycle; writes 0x033, 0x022, 0x011 on 3 consecutive cycles with o_col_id 2, 1, 0; o_rows=1.
- Same stimulus with MSB_FIRST=0 → writes 0x011, 0x022, 0x033 with o_col_id 0, 1, 2.
- SKIP_EMPTY=0 with i_fifo_empty=3'b010 held for 10 cycles → no read enable, no write, o_busy=0. Then clear empty → normal row.
- SKIP_EMPTY=1 with i_fifo_empty=3'b010 → o_read_enable=3'b101; exactly 2 writes (col 2, then col 0); o_rows=1.
- i_out_full high for 4 cycles after the first write → exactly 3 total writes, no duplicates; o_data/o_col_id held during the stall; row completes 4 cycles later.
- i_rst asserted on the cycle after the second write → zero further writes; all outputs 0 the next cycle; o_rows=0; a subsequent row drains normally.

Source files
------------

// File: rtl/col_fifo_drain.sv
// Column-FIFO drain: pops one word from every participating column FIFO and
// serialises the words, one per cycle, into the final result FIFO.
module col_fifo_drain #(
  parameter int COL        = 3,
  parameter int DW         = 9,
  parameter int MSB_FIRST  = 1,
  parameter int SKIP_EMPTY = 0,
  parameter int RCW        = 16,
  localparam int CW        = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DW*COL-1:0] i_data,
  input  logic [COL-1:0]    i_fifo_empty,
  input  logic              i_out_full,
  output logic [COL-1:0]    o_read_enable,
  output logic [DW-1:0]     o_data,
  output logic              wr_en_final_fifo,
  output logic [CW-1:0]     o_col_id,
  output logic              o_busy,
  output logic [RCW-1:0]    o_rows
);

  // Output handshake: every cycle with wr_en_final_fifo high transfers exactly
  // one word (o_data/o_col_id). i_out_full, sampled only while sending, holds
  // back the next word; o_data/o_col_id keep their last value when no write.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SNAP = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  logic [1:0]     state;
  logic [COL-1:0] mask;
  logic [DW-1:0]  snap [COL];
  logic [CW-1:0]  ptr;
  logic [CW:0]    first_hit;
  logic [CW:0]    next_hit;
  logic [DW-1:0]  cur_word;
  logic           launch;
  logic [COL-1:0] launch_mask;

  // Position of a column in emission order (0 = emitted first).
  function automatic int emit_pos(input logic [CW-1:0] col);
    return (MSB_FIRST != 0) ? (COL - 1 - int'(col)) : int'(col);
  endfunction

  // First masked column at emission position >= start; MSB is a found flag.
  function automatic logic [CW:0] scan_from(input logic [COL-1:0] m, input int start);
    logic [CW:0] hit;
    int          c;
    hit = '0;
    for (int p = COL - 1; p >= 0; p--) begin
      c = (MSB_FIRST != 0) ? (COL - 1 - p) : p;
      if (p >= start && m[c]) hit = {1'b1, c[CW-1:0]};
    end
    return hit;
  endfunction

  assign launch      = (SKIP_EMPTY != 0) ? ~&i_fifo_empty : ~|i_fifo_empty;
  assign launch_mask = (SKIP_EMPTY != 0) ? ~i_fifo_empty : '1;
  assign o_busy      = (state != ST_IDLE);

  always_comb begin
    first_hit = scan_from(mask, 0);
    next_hit  = scan_from(mask, emit_pos(ptr) + 1);
    cur_word  = '0;
    for (int c = 0; c < COL; c++) begin
      if (ptr == c[CW-1:0]) cur_word = snap[c];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      mask             <= '0;
      ptr              <= '0;
      o_read_enable    <= '0;
      o_data           <= '0;
      wr_en_final_fifo <= 1'b0;
      o_col_id         <= '0;
      o_rows           <= '0;
      for (int c = 0; c < COL; c++) snap[c] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wr_en_final_fifo <= 1'b0;
          if (launch) begin
            mask          <= launch_mask;
            o_read_enable <= launch_mask;
            state         <= ST_WAIT;
          end else begin
            o_read_enable <= '0;
          end
        end
        ST_WAIT: begin
          // FIFO read latency: popped words appear on i_data next cycle.
          o_read_enable <= '0;
          state         <= ST_SNAP;
        end
        ST_SNAP: begin
          for (int c = 0; c < COL; c++) snap[c] <= i_data[c*DW +: DW];
          ptr   <= first_hit[CW-1:0];
          state <= first_hit[CW] ? ST_SEND : ST_IDLE;
        end
        ST_SEND: begin
          if (i_out_full) begin
            wr_en_final_fifo <= 1'b0;
          end else begin
            o_data           <= cur_word;
            o_col_id         <= ptr;
            wr_en_final_fifo <= 1'b1;
            if (next_hit[CW]) begin
              ptr <= next_hit[CW-1:0];
            end else begin
              o_rows <= o_rows + RCW'(1);
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_col_fifo_drain.sv
// Bench for col_fifo_drain: four instances covering MSB_FIRST x SKIP_EMPTY,
// each fed by a column-FIFO model and checked against a queue-based row model.
module tb_col_fifo_drain;
  localparam int COL   = 3;
  localparam int DW    = 9;
  localparam int RCW   = 16;
  localparam int CW    = 2;
  localparam int DEPTH = 256;

  logic clk;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int cfg, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", cfg, nm, act, exp);
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : g_cfg
    localparam int MSB  = k % 2;
    localparam int SKIP = k / 2;

    logic              rst, out_full, wr, busy;
    logic              rst_q = 1'b1;
    logic [COL*DW-1:0] data;
    logic [COL-1:0]    fifo_empty, rd_en;
    logic [DW-1:0]     odata;
    logic [CW-1:0]     cid;
    logic [RCW-1:0]    rows;
    logic [DW-1:0]     mem [COL][DEPTH];
    int                wp [COL];
    int                rp [COL];
    int                mh [COL];
    logic [CW+DW-1:0]  exp_q [$];
    int                exp_rows;
    bit                stall_en;
    bit                done;

    col_fifo_drain #(
      .COL(COL), .DW(DW), .MSB_FIRST(MSB), .SKIP_EMPTY(SKIP), .RCW(RCW)
    ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_data(data),
      .i_fifo_empty(fifo_empty),
      .i_out_full(out_full),
      .o_read_enable(rd_en),
      .o_data(odata),
      .wr_en_final_fifo(wr),
      .o_col_id(cid),
      .o_busy(busy),
      .o_rows(rows)
    );

    // Column FIFOs with one cycle of read latency.
    always_comb begin
      fifo_empty = '0;
      for (int c = 0; c < COL; c++) fifo_empty[c] = (rp[c] == wp[c]);
    end

    always @(posedge clk) begin
      rst_q <= rst;
      for (int c = 0; c < COL; c++) begin
        if (rd_en[c]) begin
          data[c*DW +: DW] <= mem[c][rp[c]];
          rp[c]            <= rp[c] + 1;
        end
      end
    end

    task automatic push_word(input int c, input logic [DW-1:0] w);
      mem[c][wp[c]] = w;
      wp[c]++;
    endtask

    // Reference: form rows from the queued words until no launch is possible.
    task automatic model_drain();
      int ord [COL];
      bit any_ne, all_ne;
      int c;
      logic [CW-1:0] cc;
      for (int i = 0; i < COL; i++) ord[i] = (MSB != 0) ? (COL - 1 - i) : i;
      forever begin
        any_ne = 1'b0;
        all_ne = 1'b1;
        for (int i = 0; i < COL; i++) begin
          if (mh[i] < wp[i]) any_ne = 1'b1;
          else all_ne = 1'b0;
        end
        if ((SKIP != 0) ? !any_ne : !all_ne) break;
        for (int i = 0; i < COL; i++) begin
          c = ord[i];
          if (mh[c] < wp[c]) begin
            cc = c[CW-1:0];
            exp_q.push_back({cc, mem[c][mh[c]]});
            mh[c]++;
          end
        end
        exp_rows++;
      end
    endtask

    task automatic wait_quiet();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy || wr) && t < 3000) begin
        out_full = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
        @(negedge clk);
        t++;
      end
      out_full = 1'b0;
      chk(k, "drain_done", t < 3000, 1);
    endtask

    initial begin : monitor
      logic [CW+DW-1:0] last, got;
      last = '0;
      forever begin
        @(negedge clk);
        got = {cid, odata};
        if (rst_q) begin
          last = '0;
          chk(k, "reset_outputs", {busy, wr, rd_en, rows, cid, odata}, 64'd0);
        end else begin
          for (int c = 0; c < COL; c++)
            if (rd_en[c]) chk(k, "pop_nonempty", rp[c] < wp[c], 1);
          if (wr) begin
            chk(k, "write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk(k, "write_word", got, exp_q.pop_front());
            last = got;
          end else begin
            chk(k, "hold_outputs", got, last);
          end
        end
      end
    end

    initial begin : stim
      int n, t, cnt, pulses, writes;
      logic [COL-1:0] re0, exp_mask;
      rst      = 1'b1;
      out_full = 1'b0;
      stall_en = 1'b0;
      done     = 1'b0;
      repeat (3) @(negedge clk);
      chk(k, "reset_state", {busy, wr, rd_en, rows, cid, odata}, 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Fixed row: launch-to-strobe latency and emission order.
      push_word(0, 9'h011);
      push_word(1, 9'h022);
      push_word(2, 9'h033);
      model_drain();
      @(negedge clk);
      chk(k, "launch_read_enable", rd_en, 3'b111);
      @(negedge clk);
      chk(k, "read_enable_one_cycle", rd_en, 3'b000);
      @(negedge clk);
      chk(k, "no_write_in_snap", wr, 0);
      @(negedge clk);
      chk(k, "first_write_latency", wr, 1);
      wait_quiet();
      chk(k, "rows_after_first", rows, exp_rows);

      // Column 1 empty: SKIP_EMPTY decides whether a partial row launches.
      push_word(0, DW'($urandom_range(0, 511)));
      push_word(2, DW'($urandom_range(0, 511)));
      model_drain();
      pulses = 0;
      writes = 0;
      re0    = '0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (i == 0) re0 = rd_en;
        if (rd_en != 0) pulses++;
        if (wr) writes++;
      end
      exp_mask = (SKIP != 0) ? 3'b101 : 3'b000;
      chk(k, "partial_mask", re0, exp_mask);
      chk(k, "partial_pulses", pulses, (SKIP != 0) ? 1 : 0);
      chk(k, "partial_writes", writes, (SKIP != 0) ? 2 : 0);
      chk(k, "partial_idle", busy, 0);
      push_word(1, DW'($urandom_range(0, 511)));
      model_drain();
      wait_quiet();
      chk(k, "rows_after_partial", rows, exp_rows);

      // Four stalled cycles right after the first write of a row.
      for (int c = 0; c < COL; c++) push_word(c, DW'($urandom_range(0, 511)));
      model_drain();
      t = 0;
      while (!wr && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk(k, "stall_first_write", wr, 1);
      n = int'(wr);
      out_full = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (wr) n++;
      end
      out_full = 1'b0;
      @(negedge clk);
      if (wr) n++;
      chk(k, "rows_during_stall", rows, exp_rows - 1);
      @(negedge clk);
      if (wr) n++;
      chk(k, "rows_after_stall", rows, exp_rows);
      chk(k, "stall_write_count", n, 3);
      wait_quiet();

      // Reset after the second write discards the rest of the row.
      for (int c = 0; c < COL; c++) push_word(c, DW'($urandom_range(0, 511)));
      model_drain();
      void'(exp_q.pop_back());
      exp_rows--;
      n = 0;
      t = 0;
      while (n < 2 && t < 30) begin
        @(negedge clk);
        if (wr) n++;
        t++;
      end
      chk(k, "two_writes_before_reset", n, 2);
      rst = 1'b1;
      @(negedge clk);
      chk(k, "reset_mid_row", {busy, wr, rd_en, rows, cid, odata}, 64'd0);
      exp_rows = 0;
      rst = 1'b0;
      n = 0;
      repeat (5) begin
        @(negedge clk);
        if (wr) n++;
      end
      chk(k, "no_writes_after_reset", n, 0);
      chk(k, "expected_consumed", exp_q.size(), 0);
      for (int c = 0; c < COL; c++) push_word(c, DW'($urandom_range(0, 511)));
      model_drain();
      wait_quiet();
      chk(k, "rows_after_reset_row", rows, exp_rows);

      // Random loads with random backpressure.
      for (int it = 0; it < 24; it++) begin
        stall_en = ($urandom_range(0, 1) == 1);
        for (int c = 0; c < COL; c++) begin
          cnt = $urandom_range(0, 3);
          for (int j = 0; j < cnt; j++) push_word(c, DW'($urandom_range(0, 511)));
        end
        model_drain();
        wait_quiet();
        chk(k, "rows_random", rows, exp_rows);
      end
      stall_en = 1'b0;
      done = 1'b1;
    end
  end

  initial begin : finale
    int t;
    t = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    chk(0, "all_configs_done", t < 40000, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
